// File: rtl/text_cmd_sequencer.sv
// Command FIFO + sequencer in front of the text area; tracks the cursor and expands put-char/newline.
// Optional `TEXT_CMD_SEQ_LEVEL_EN adds o_level / o_overflow.
module text_cmd_sequencer #(
   parameter int FIFO_DEPTH = 16,
   parameter int NUM_COLS   = 84,
   parameter int NUM_ROWS   = 64
) (
   input  logic                          i_cmd_clk,
   input  logic                          i_rst,
   input  logic                          i_wr_valid,
   input  logic [31:0]                   i_wr_data,
   output logic                          o_wr_ready,
   output logic                          o_cmd_valid,
   output logic [31:0]                   o_cmd_data,
   input  logic                          i_cmd_ready,
   output logic [5:0]                    o_cursor_row,
   output logic [6:0]                    o_cursor_column,
`ifdef TEXT_CMD_SEQ_LEVEL_EN
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_overflow,
`endif
   output logic                          o_busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L  = (AW+1)'(FIFO_DEPTH);
   localparam logic [6:0]  LAST_COL = 7'(NUM_COLS-1);
   localparam logic [5:0]  LAST_ROW = 6'(NUM_ROWS-1);

   typedef enum logic [1:0] {IDLE, SEND, EXP_CURSOR, EXP_CELL} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr, w_level;
   logic        w_empty, w_full, w_push, w_pop;
   logic [31:0] w_head;

   logic        r_valid, w_valid_nxt;
   logic [31:0] r_data, w_data_nxt;
   logic [5:0]  r_row, w_row_nxt, r_pend_row, w_pend_row_nxt, w_row_inc;
   logic [6:0]  r_col, w_col_nxt, r_pend_col, w_pend_col_nxt, w_clamp_col;
   logic        r_pend_upd, w_pend_upd_nxt;
   logic [15:0] r_char, w_char_nxt;

   assign w_level    = r_wr_ptr - r_rd_ptr;
   assign w_empty    = (w_level == '0);
   assign w_full     = (w_level == DEPTH_L);
   assign w_push     = i_wr_valid && !w_full;
   assign w_pop      = (r_state == IDLE) && !w_empty;
   assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
   assign w_row_inc  = (r_row == LAST_ROW) ? 6'd0 : r_row + 6'd1;
   assign w_clamp_col = (w_head[14:8] > LAST_COL) ? LAST_COL : w_head[14:8];

   // FIFO storage needs no reset; occupancy lives entirely in the pointers.
   always_ff @(posedge i_cmd_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   always_ff @(posedge i_cmd_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_cmd_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:       if (!w_empty) w_state_nxt = (w_head[31:28] == 4'b1100) ? EXP_CURSOR : SEND;
         SEND:       if (i_cmd_ready) w_state_nxt = IDLE;
         EXP_CURSOR: if (i_cmd_ready) w_state_nxt = EXP_CELL;
         EXP_CELL:   if (i_cmd_ready) w_state_nxt = IDLE;
         default:    w_state_nxt = IDLE;
      endcase
   end

   // Cursor loads/newlines are parked in r_pend_* until their word is accepted.
   always_comb begin
      w_valid_nxt    = r_valid;
      w_data_nxt     = r_data;
      w_row_nxt      = r_row;
      w_col_nxt      = r_col;
      w_pend_row_nxt = r_pend_row;
      w_pend_col_nxt = r_pend_col;
      w_pend_upd_nxt = r_pend_upd;
      w_char_nxt     = r_char;
      case (r_state)
         IDLE: if (!w_empty) begin
            w_valid_nxt = 1'b1;
            case (w_head[31:28])
               4'b0111: begin
                  w_data_nxt     = {w_head[31:15], w_clamp_col, w_head[7:0]};
                  w_pend_upd_nxt = 1'b1;
                  w_pend_col_nxt = w_clamp_col;
                  w_pend_row_nxt = w_head[5:0];
               end
               4'b1100: begin
                  w_data_nxt = {4'b0111, 13'd0, r_col, 2'b00, r_row};
                  w_char_nxt = w_head[15:0];
               end
               4'b1101: begin
                  w_data_nxt     = {4'b0111, 13'd0, 7'd0, 2'b00, w_row_inc};
                  w_pend_upd_nxt = 1'b1;
                  w_pend_col_nxt = 7'd0;
                  w_pend_row_nxt = w_row_inc;
               end
               default: begin
                  w_data_nxt     = w_head;
                  w_pend_upd_nxt = 1'b0;
               end
            endcase
         end
         SEND: if (i_cmd_ready) begin
            w_valid_nxt    = 1'b0;
            w_pend_upd_nxt = 1'b0;
            if (r_pend_upd) begin
               w_row_nxt = r_pend_row;
               w_col_nxt = r_pend_col;
            end
         end
         EXP_CURSOR: if (i_cmd_ready) w_data_nxt = {4'b1000, 12'd0, r_char};
         EXP_CELL: if (i_cmd_ready) begin
            w_valid_nxt = 1'b0;
            if (r_col == LAST_COL) begin
               w_col_nxt = 7'd0;
               w_row_nxt = w_row_inc;
            end else begin
               w_col_nxt = r_col + 7'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_cmd_clk) begin
      if (i_rst) begin
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_pend_row <= '0;
         r_pend_col <= '0;
         r_pend_upd <= 1'b0;
         r_char     <= '0;
      end else begin
         r_valid    <= w_valid_nxt;
         r_data     <= w_data_nxt;
         r_row      <= w_row_nxt;
         r_col      <= w_col_nxt;
         r_pend_row <= w_pend_row_nxt;
         r_pend_col <= w_pend_col_nxt;
         r_pend_upd <= w_pend_upd_nxt;
         r_char     <= w_char_nxt;
      end
   end

`ifdef TEXT_CMD_SEQ_LEVEL_EN
   logic r_overflow;
   always_ff @(posedge i_cmd_clk) begin
      if (i_rst)                   r_overflow <= 1'b0;
      else if (i_wr_valid && w_full) r_overflow <= 1'b1;
   end
   assign o_level    = w_level;
   assign o_overflow = r_overflow;
`endif

   assign o_wr_ready      = !w_full;
   assign o_cmd_valid     = r_valid;
   assign o_cmd_data      = r_data;
   assign o_cursor_row    = r_row;
   assign o_cursor_column = r_col;
   assign o_busy          = !w_empty || (r_state != IDLE) || r_valid;
endmodule

// File: tb/tb_text_cmd_sequencer.sv
// Scoreboard bench for text_cmd_sequencer: expected words queued at stimulus, popped by a monitor on acceptance.
module tb_text_cmd_sequencer;
   logic        clk = 1'b0;
   logic        rst, wr_valid, wr_ready, cmd_valid, cmd_ready, busy;
   logic [31:0] wr_data, cmd_data;
   logic [5:0]  row;
   logic [6:0]  col;
`ifdef TEXT_CMD_SEQ_LEVEL_EN
   logic [4:0]  level;
   logic        overflow;
`endif

   text_cmd_sequencer dut (
      .i_cmd_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
      .o_wr_ready(wr_ready), .o_cmd_valid(cmd_valid), .o_cmd_data(cmd_data),
      .i_cmd_ready(cmd_ready), .o_cursor_row(row), .o_cursor_column(col),
`ifdef TEXT_CMD_SEQ_LEVEL_EN
      .o_level(level), .o_overflow(overflow),
`endif
      .o_busy(busy));

   always #5 clk = ~clk;

   int          n_pass = 0, n_total = 0;
   logic [31:0] expq [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic push_w(input logic [31:0] w);
      wr_valid = 1'b1;
      wr_data  = w;
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k;
      for (k = 0; k < 300; k++) begin
         @(posedge clk); #2;
         if (expq.size() == 0 && !busy) break;
      end
      chk({nm, "_drained"}, 32'(k < 300), 32'd1);
   endtask

   task automatic monitor();
      logic        stall = 1'b0;
      logic [31:0] held  = '0;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (stall && cmd_valid) chk("hold_stable", cmd_data, held);
         stall = cmd_valid && !cmd_ready;
         held  = cmd_data;
         if (cmd_valid && cmd_ready) begin
            if (expq.size() == 0) chk("unexpected_cmd", cmd_data, 32'hxxxx_xxxx);
            else begin
               e = expq.pop_front();
               chk("cmd_word", cmd_data, e);
            end
         end
      end
   endtask

   initial begin
      int acc;
      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; cmd_ready = 1'b1;
      fork monitor(); join_none
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_data", cmd_data, 32'd0);
      chk("rst_row", 32'(row), 32'd0);
      chk("rst_col", 32'(col), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef TEXT_CMD_SEQ_LEVEL_EN
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
`endif

      // Latency: pushed in cycle N, valid in N+2, one-cycle pulse.
      expq.push_back(32'h1000_0005);
      push_w(32'h1000_0005);
      chk("lat_n1_valid", 32'(cmd_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_n2_valid", 32'(cmd_valid), 32'd1);
      chk("lat_n2_data", cmd_data, 32'h1000_0005);
      @(posedge clk); #1;
      chk("pulse_end", 32'(cmd_valid), 32'd0);
      drain("pass1");
      chk("idle_busy", 32'(busy), 32'd0);

      // Cursor load then put char.
      expq.push_back(32'h7000_0A03); expq.push_back(32'h7000_0A03); expq.push_back(32'h8000_F241);
      push_w(32'h7000_0A03); push_w(32'hC000_F241);
      drain("putc");
      chk("putc_col", 32'(col), 32'd11);
      chk("putc_row", 32'(row), 32'd3);

      // Put char at the last cell wraps to 0,0.
      expq.push_back(32'h7000_533F); expq.push_back(32'h7000_533F); expq.push_back(32'h8000_1F41);
      push_w(32'h7000_533F); push_w(32'hC000_1F41);
      drain("wrap");
      chk("wrap_col", 32'(col), 32'd0);
      chk("wrap_row", 32'(row), 32'd0);

      // Newline.
      expq.push_back(32'h7000_1405); expq.push_back(32'h7000_0006);
      push_w(32'h7000_1405); push_w(32'hD000_0000);
      drain("nl");
      chk("nl_col", 32'(col), 32'd0);
      chk("nl_row", 32'(row), 32'd6);

      // Column clamp, then put char from the clamped column.
      expq.push_back(32'h7000_5302); expq.push_back(32'h7000_5302); expq.push_back(32'h8000_0041);
      push_w(32'h7000_7F02); push_w(32'hC000_0041);
      drain("clamp");
      chk("clamp_col", 32'(col), 32'd0);
      chk("clamp_row", 32'(row), 32'd3);

      // Newline on last row wraps; pass-through leaves the cursor alone.
      expq.push_back(32'h7000_0A3F); expq.push_back(32'h7000_0000); expq.push_back(32'h0000_1234);
      push_w(32'h7000_0A3F); push_w(32'hD000_0000); push_w(32'h0000_1234);
      drain("nlwrap");
      chk("nlwrap_col", 32'(col), 32'd0);
      chk("nlwrap_row", 32'(row), 32'd0);

      // Fill with output stalled: 17 accepted (16 in FIFO + output reg), 18th dropped.
      cmd_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 18; i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'h2000_0000 + 32'(i);
         if (wr_ready) begin
            acc++;
            expq.push_back(wr_data);
         end
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      chk("full_accepted", 32'(acc), 32'd17);
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      chk("full_valid", 32'(cmd_valid), 32'd1);
      chk("full_head", cmd_data, 32'h2000_0000);
`ifdef TEXT_CMD_SEQ_LEVEL_EN
      chk("full_level", 32'(level), 32'd16);
      chk("full_overflow", 32'(overflow), 32'd1);
`endif
      repeat (3) @(posedge clk);
      #1 cmd_ready = 1'b1;
      drain("fill");
`ifdef TEXT_CMD_SEQ_LEVEL_EN
      chk("sticky_overflow", 32'(overflow), 32'd1);
`endif

      // Reset in EXP_CURSOR with three words queued behind.
      expq.push_back(32'h7000_0A03);
      push_w(32'h7000_0A03);
      drain("pre_rst");
      cmd_ready = 1'b0;
      expq.push_back(32'h7000_0A03);
      push_w(32'hC000_F241);
      push_w(32'h3000_0001); push_w(32'h3000_0002); push_w(32'h3000_0003);
      chk("exp_valid", 32'(cmd_valid), 32'd1);
      chk("exp_data", cmd_data, 32'h7000_0A03);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expq.delete();
      chk("abort_valid", 32'(cmd_valid), 32'd0);
      chk("abort_wr_ready", 32'(wr_ready), 32'd1);
      chk("abort_row", 32'(row), 32'd0);
      chk("abort_col", 32'(col), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
`ifdef TEXT_CMD_SEQ_LEVEL_EN
      chk("abort_level", 32'(level), 32'd0);
      chk("abort_overflow", 32'(overflow), 32'd0);
`endif
      cmd_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1 chk("post_abort_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/text_cmd_sequencer.md
Name: text_cmd_sequencer

Overview:
- Command front end directly upstream of the 8x8 text area.
- Buffers 32-bit text-area commands from the CPU/bus side in a FIFO and issues them one at a time through a valid/ready handshake.
- Tracks the text cursor itself. Expands two sequencer-only opcodes ("put char and advance", "newline") into the native cursor/cell command pairs.
- Lets software stream characters without computing cursor positions.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of two, minimum 2.
- NUM_COLS, 84, text columns in the cell array; column wraps at NUM_COLS-1.
- NUM_ROWS, 64, text rows in the cell array; row wraps at NUM_ROWS-1.

Ports:
- i_cmd_clk  input  1  command clock; all logic on rising edge.
- i_rst  input  1  reset.
- i_wr_valid  input  1  host command valid.
- i_wr_data  input  32  host command word.
- o_wr_ready  output  1  FIFO not full; write accepted when i_wr_valid && o_wr_ready.
- o_cmd_valid  output  1  command word presented to text area.
- o_cmd_data  output  32  command word.
- i_cmd_ready  input  1  text area accepts o_cmd_data this cycle.
- o_cursor_row  output  6  tracked cursor row.
- o_cursor_column  output  7  tracked cursor column.
- o_busy  output  1  FIFO non-empty or a command is pending on the output.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (i_rst sampled on i_cmd_clk rising edge).
- Reset values:
  - FIFO empty; o_wr_ready=1.
  - o_cmd_valid=0, o_cmd_data=0.
  - Cursor 0,0; o_busy=0.
  - State IDLE.
- Reset mid-expansion aborts it and discards all FIFO contents.
- FIFO write: accepted when i_wr_valid && o_wr_ready. Simultaneous push and pop while full is not allowed, because o_wr_ready=0 when full. Push and pop in the same cycle when non-empty keep the level unchanged.
- Output handshake:
  - o_cmd_data/o_cmd_valid are registered.
  - Once o_cmd_valid=1, o_cmd_data holds stable until a cycle with i_cmd_ready=1.
  - The next word may be presented the cycle after acceptance, giving at most one command per cycle.
- Latency: a word pushed into an empty FIFO in cycle N appears with o_cmd_valid=1 in cycle N+2.
- Cursor command (0111) layout: bits 31:28=0111, 14:8=column, 5:0=row.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and decode:
    - 0111 -> load cursor from bits 14:8/5:0; emit the word unchanged; go to SEND.
    - 1100 (put char) -> emit {0111, zeros, column, 00, row}; go to EXP_CURSOR. Bits 15:0 are latched as FG/BG/char.
    - 1101 (newline) -> column=0, row=row+1 (wraps to 0 past NUM_ROWS-1); emit the matching 0111; go to SEND.
    - Any other opcode, including 0000 -> pass through unchanged; go to SEND.
  - SEND: hold until i_cmd_ready; then go to IDLE.
  - EXP_CURSOR: hold until i_cmd_ready; then emit {1000, 12'b0, latched[15:0]}; go to EXP_CELL.
  - EXP_CELL: hold until i_cmd_ready; then advance the cursor and go to IDLE.
- Cursor advance rules:
  - column+1.
  - At NUM_COLS-1: column=0, row+1.
  - Row at NUM_ROWS-1 wraps to 0.
- Cursor updates take effect on the acceptance cycle of the last emitted word. o_cursor_* always reflect the position the next put-char will use.
- Out-of-range 0111 values (column>=NUM_COLS) are clamped to NUM_COLS-1 both in the tracker and in the emitted word.
- o_busy = FIFO non-empty || state!=IDLE || o_cmd_valid.

Optional Feature:
- Macro: TEXT_CMD_SEQ_LEVEL_EN.
- Defined: adds output o_level [$clog2(FIFO_DEPTH):0] (current FIFO occupancy, 0 after reset) and sticky output o_overflow. o_overflow sets when i_wr_valid=1 while o_wr_ready=0 and clears only on reset.
- Undefined: neither port exists; the dropped-write condition is not tracked.

Test Plan:
- Reset then push 0x1000_0005 with i_cmd_ready=1 -> o_cmd_valid rises 2 cycles after push with o_cmd_data=0x1000_0005; pulse lasts 1 cycle; o_busy returns to 0.
- Push 0x7000_0A03, then 0xC000_F241 -> emitted sequence 0x7000_0A03, 0x7000_0A03, 0x8000_F241; cursor afterwards column=11, row=3.
- Cursor at column 83, row 63; put char 0xC000_1F41 -> emits 0x7000_533F then 0x8000_1F41; cursor afterwards 0,0.
- Cursor column 20, row 5; push 0xD000_0000 -> emits 0x7000_0006; cursor 0,6.
- Hold i_cmd_ready=0, push 17 words with FIFO_DEPTH=16 -> o_wr_ready=0 after 16 accepted pushes plus the one in the output register; o_cmd_data stays stable; releasing ready drains all in order with none lost; with TEXT_CMD_SEQ_LEVEL_EN, o_overflow=1 if extra valid was held.
- Assert i_rst during EXP_CURSOR with 3 words queued -> next cycle o_cmd_valid=0, o_wr_ready=1, cursor 0,0, no further commands emitted.
